// File: rtl/nano_mem_arbiter.sv
// Shares one single-port synchronous word memory between the instruction-fetch port and the
// load/store data port. Data has priority; a starvation counter forces a fetch grant after
// STARVE_LIMIT consecutive fetch denials. Read data returns one cycle after the grant.
module nano_mem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  // Instruction-fetch port
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_valid,
  output logic [DATA_W-1:0] o_if_rdata,
  // Load/store data port
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  input  logic [3:0]        i_d_wstrb,
  output logic              o_d_gnt,
  output logic              o_d_valid,
  output logic [DATA_W-1:0] o_d_rdata,
  // Shared memory
  output logic              o_mem_en,
  output logic [3:0]        o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  logic [3:0] starve_q, starve_d;
  logic       if_pend_q, if_pend_d;
  logic       d_pend_q, d_pend_d;
  logic       force_fetch;

  // Arbitration, memory command and next-state for the response tags and starvation counter
  always_comb begin
    force_fetch = i_if_req & (starve_q == StarveMax);
    // Grants are suppressed while reset is held so no command reaches the memory.
    o_if_gnt    = ~i_rst & i_if_req & (force_fetch | ~i_d_req);
    o_d_gnt     = ~i_rst & i_d_req & ~o_if_gnt;

    o_mem_en    = o_if_gnt | o_d_gnt;
    o_mem_addr  = '0;
    if (o_if_gnt) begin
      o_mem_addr = i_if_addr;
    end else if (o_d_gnt) begin
      o_mem_addr = i_d_addr;
    end
    o_mem_we    = (o_d_gnt & i_d_we) ? i_d_wstrb : 4'b0000;
    o_mem_wdata = o_d_gnt ? i_d_wdata : '0;

    if_pend_d   = o_if_gnt;
    // Stores complete in their grant cycle and never produce a response.
    d_pend_d    = o_d_gnt & ~i_d_we;

    if (i_if_req & ~o_if_gnt) begin
      starve_d = (starve_q >= StarveMax) ? StarveMax : starve_q + 4'd1;
    end else begin
      starve_d = 4'd0;
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      starve_q  <= 4'd0;
      if_pend_q <= 1'b0;
      d_pend_q  <= 1'b0;
    end else begin
      starve_q  <= starve_d;
      if_pend_q <= if_pend_d;
      d_pend_q  <= d_pend_d;
    end
  end

  // Response routing; valids are gated by reset so a response pending across reset is dropped
  always_comb begin
    o_if_valid = if_pend_q & ~i_rst;
    o_d_valid  = d_pend_q & ~i_rst;
    o_if_rdata = o_if_valid ? i_mem_rdata : '0;
    o_d_rdata  = o_d_valid ? i_mem_rdata : '0;
  end

endmodule

// File: tb/tb_nano_mem_arbiter.sv
// Self-checking bench for nano_mem_arbiter: directed stimulus pushes expected read data into
// per-port queues; a monitor pops and compares whenever a valid is presented.
module tb_nano_mem_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_gnt;
  logic        o_if_valid;
  logic [31:0] o_if_rdata;
  logic        i_d_req;
  logic        i_d_we;
  logic [31:0] i_d_addr;
  logic [31:0] i_d_wdata;
  logic [3:0]  i_d_wstrb;
  logic        o_d_gnt;
  logic        o_d_valid;
  logic [31:0] o_d_rdata;
  logic        o_mem_en;
  logic [3:0]  o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata;

  int checks   = 0;
  int failures = 0;

  logic [31:0] if_q[$];
  logic [31:0] d_q[$];

  nano_mem_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .STARVE_LIMIT(4)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_if_req   (i_if_req),
    .i_if_addr  (i_if_addr),
    .o_if_gnt   (o_if_gnt),
    .o_if_valid (o_if_valid),
    .o_if_rdata (o_if_rdata),
    .i_d_req    (i_d_req),
    .i_d_we     (i_d_we),
    .i_d_addr   (i_d_addr),
    .i_d_wdata  (i_d_wdata),
    .i_d_wstrb  (i_d_wstrb),
    .o_d_gnt    (o_d_gnt),
    .o_d_valid  (o_d_valid),
    .o_d_rdata  (o_d_rdata),
    .o_mem_en   (o_mem_en),
    .o_mem_we   (o_mem_we),
    .o_mem_addr (o_mem_addr),
    .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  // Behavioural single-port RAM, 256 words, byte-writable, 1-cycle read latency.
  // Contents: word i = 0xA0000000 | i, except [5]=0x00500093, [0x10]=0x11223344,
  // [0x40]=0xCAFE0040.
  logic [31:0] mem[256];
  logic        init_done = 1'b0;
  logic [31:0] mem_rd    = 32'h0;
  assign i_mem_rdata = mem_rd;

  always @(posedge i_clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | 32'(i);
      mem[5]    <= 32'h0050_0093;
      mem[8'h10] <= 32'h1122_3344;
      mem[8'h40] <= 32'hCAFE_0040;
      init_done <= 1'b1;
    end else if (o_mem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (o_mem_we[b]) mem[o_mem_addr[7:0]][8*b +: 8] <= o_mem_wdata[8*b +: 8];
      end
      mem_rd <= mem[o_mem_addr[7:0]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs shortly after the rising edge; return mid-cycle for checks.
  task automatic drive(input logic rst, input logic ir, input logic [31:0] ia, input logic dr,
                       input logic dwe, input logic [31:0] da, input logic [31:0] wd,
                       input logic [3:0] ws);
    @(posedge i_clk);
    #1;
    i_rst     = rst;
    i_if_req  = ir;
    i_if_addr = ia;
    i_d_req   = dr;
    i_d_we    = dwe;
    i_d_addr  = da;
    i_d_wdata = wd;
    i_d_wstrb = ws;
    #2;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  // Monitor: compare response data against the scoreboard on the falling edge
  always @(negedge i_clk) begin
    if (o_if_valid) begin
      if (if_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL if_unexpected_valid: got valid=1 expected valid=0");
      end else begin
        chk("if_rdata", o_if_rdata, if_q.pop_front());
      end
    end else if (init_done) begin
      chk("if_rdata_idle_zero", o_if_rdata, 32'h0);
    end
    if (o_d_valid) begin
      if (d_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL d_unexpected_valid: got valid=1 expected valid=0");
      end else begin
        chk("d_rdata", o_d_rdata, d_q.pop_front());
      end
    end
  end

  initial begin
    i_rst = 1'b1; i_if_req = 1'b1; i_if_addr = 32'd5; i_d_req = 1'b1; i_d_we = 1'b0;
    i_d_addr = 32'h40; i_d_wdata = 32'h0; i_d_wstrb = 4'h0;

    // Reset with both requests asserted
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 1'b1, 32'd5, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
      chk("rst_if_gnt", 32'(o_if_gnt), 32'h0);
      chk("rst_d_gnt", 32'(o_d_gnt), 32'h0);
      chk("rst_mem_en", 32'(o_mem_en), 32'h0);
      chk("rst_mem_we", 32'(o_mem_we), 32'h0);
      chk("rst_if_valid", 32'(o_if_valid), 32'h0);
      chk("rst_d_valid", 32'(o_d_valid), 32'h0);
    end

    // First fetch after reset
    drive(1'b0, 1'b1, 32'd5, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("fetch_gnt", 32'(o_if_gnt), 32'h1);
    chk("fetch_mem_addr", o_mem_addr, 32'd5);
    chk("fetch_mem_we", 32'(o_mem_we), 32'h0);
    if_q.push_back(32'h0050_0093);

    // Contention: data load wins
    drive(1'b0, 1'b1, 32'd6, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    chk("cont_d_gnt", 32'(o_d_gnt), 32'h1);
    chk("cont_if_gnt", 32'(o_if_gnt), 32'h0);
    chk("cont_mem_addr", o_mem_addr, 32'h40);
    chk("cont_mem_we", 32'(o_mem_we), 32'h0);
    d_q.push_back(32'hCAFE_0040);
    idle();
    chk("cont_d_valid", 32'(o_d_valid), 32'h1);
    idle();

    // Starvation: fetch forced in cycles 4 and 9
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 1'b1, 32'd7, 1'b1, 1'b0, 32'h41, 32'h0, 4'h0);
      if (c == 4 || c == 9) begin
        chk($sformatf("starve_if_gnt_c%0d", c), 32'(o_if_gnt), 32'h1);
        chk($sformatf("starve_d_gnt_c%0d", c), 32'(o_d_gnt), 32'h0);
        if_q.push_back(32'hA000_0007);
      end else begin
        chk($sformatf("starve_if_gnt_c%0d", c), 32'(o_if_gnt), 32'h0);
        chk($sformatf("starve_d_gnt_c%0d", c), 32'(o_d_gnt), 32'h1);
        d_q.push_back(32'hA000_0041);
      end
    end
    idle();

    // Store: byte lanes 0-1 only, no response
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'b0011);
    chk("st_d_gnt", 32'(o_d_gnt), 32'h1);
    chk("st_mem_we", 32'(o_mem_we), 32'h3);
    chk("st_mem_wdata", o_mem_wdata, 32'hDEAD_BEEF);
    chk("st_mem_addr", o_mem_addr, 32'h10);
    idle();
    chk("st_no_d_valid", 32'(o_d_valid), 32'h0);
    // Reload shows only the enabled lanes were written
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    chk("ld_mem_we", 32'(o_mem_we), 32'h0);
    d_q.push_back(32'h1122_BEEF);
    idle();

    // Reset mid-operation drops the pending fetch response
    drive(1'b0, 1'b1, 32'd8, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("rmid_if_gnt", 32'(o_if_gnt), 32'h1);
    drive(1'b1, 1'b1, 32'd8, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    chk("rmid_if_valid", 32'(o_if_valid), 32'h0);
    chk("rmid_gnts", {30'h0, o_if_gnt, o_d_gnt}, 32'h0);
    drive(1'b1, 1'b1, 32'd8, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    chk("rmid_starve", 32'(dut.starve_q), 32'h0);
    chk("rmid_gnts2", {30'h0, o_if_gnt, o_d_gnt}, 32'h0);
    chk("rmid_mem_en", 32'(o_mem_en), 32'h0);
    idle();

    // Back-to-back fetches 0,1,2
    for (int a = 0; a < 3; a++) begin
      drive(1'b0, 1'b1, 32'(a), 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      chk($sformatf("b2b_gnt_%0d", a), 32'(o_if_gnt), 32'h1);
      chk($sformatf("b2b_addr_%0d", a), o_mem_addr, 32'(a));
      if (a > 0) chk($sformatf("b2b_valid_%0d", a), 32'(o_if_valid), 32'h1);
      if_q.push_back(32'hA000_0000 | 32'(a));
    end
    idle();
    chk("b2b_valid_last", 32'(o_if_valid), 32'h1);
    idle();
    idle();

    chk("if_queue_drained", 32'(if_q.size()), 32'h0);
    chk("d_queue_drained", 32'(d_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against any unexpected stall
  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
